// File: rtl/jedro_1_mtimer_pkg.sv
// rtl/jedro_1_mtimer_pkg.sv - register offsets, reset values and helpers for the machine timer
package jedro_1_mtimer_pkg;

    localparam int MTIMER_OFF_MSIP        = 'h00;
    localparam int MTIMER_OFF_MTIMECMP_LO = 'h08;
    localparam int MTIMER_OFF_MTIMECMP_HI = 'h0C;
    localparam int MTIMER_OFF_MTIME_LO    = 'h10;
    localparam int MTIMER_OFF_MTIME_HI    = 'h14;

    localparam logic [63:0] MTIMER_DEF_VAL_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_e;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/jedro_1_mtimer_if.sv
// rtl/jedro_1_mtimer_if.sv - LSU data bus port of the machine timer
interface jedro_1_mtimer_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  err;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/jedro_1_prescaler.sv
// rtl/jedro_1_prescaler.sv - free-running divider producing one tick every PRESCALE cycles
module jedro_1_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/jedro_1_mtimer.sv
// rtl/jedro_1_mtimer.sv - memory-mapped mtime/mtimecmp/msip with timer and software interrupts
module jedro_1_mtimer
    import jedro_1_mtimer_pkg::*;
#(
    parameter int PRESCALE   = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    jedro_1_mtimer_if.slave    bus,
    output logic               timer_irq_o,
    output logic               sw_irq_o
);
    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    reg_sel_e    sel;
    logic [31:0] rd_val;
    logic        rvalid_q, err_q;
    logic [31:0] rdata_q;

    jedro_1_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    assign bus.gnt    = bus.req;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

    // Misaligned offsets never select a register, so they fall through to the error path.
    always_comb begin
        sel = REG_NONE;
        if (bus.addr[1:0] == 2'b00) begin
            case (bus.addr)
                ADDR_WIDTH'(MTIMER_OFF_MSIP):        sel = REG_MSIP;
                ADDR_WIDTH'(MTIMER_OFF_MTIMECMP_LO): sel = REG_CMP_LO;
                ADDR_WIDTH'(MTIMER_OFF_MTIMECMP_HI): sel = REG_CMP_HI;
                ADDR_WIDTH'(MTIMER_OFF_MTIME_LO):    sel = REG_TIME_LO;
                ADDR_WIDTH'(MTIMER_OFF_MTIME_HI):    sel = REG_TIME_HI;
                default:                             sel = REG_NONE;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_MSIP:    rd_val = {31'b0, msip_q};
            REG_CMP_LO:  rd_val = mtimecmp_q[31:0];
            REG_CMP_HI:  rd_val = mtimecmp_q[63:32];
            REG_TIME_LO: rd_val = mtime_q[31:0];
            REG_TIME_HI: rd_val = mtime_q[63:32];
            default:     rd_val = '0;
        endcase
    end

    // The unwritten half of mtime keeps the incremented value, so a tick's carry survives a write.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (bus.req && bus.we) begin
            case (sel)
                REG_MSIP:    if (bus.be[0]) msip_d = bus.wdata[0];
                REG_CMP_LO:  mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0], bus.wdata, bus.be);
                REG_CMP_HI:  mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], bus.wdata, bus.be);
                REG_TIME_LO: mtime_d[31:0]     = apply_be(mtime_q[31:0], bus.wdata, bus.be);
                REG_TIME_HI: mtime_d[63:32]    = apply_be(mtime_q[63:32], bus.wdata, bus.be);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMER_DEF_VAL_MTIMECMP;
            msip_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timer_irq_o <= 1'b0;
            sw_irq_o    <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            rvalid_q    <= bus.req;
            rdata_q     <= bus.req ? rd_val : '0;
            err_q       <= bus.req && (sel == REG_NONE);
            timer_irq_o <= (mtime_q >= mtimecmp_q);
            sw_irq_o    <= msip_q;
        end
    end
endmodule
